// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters,
// combinational lookup, trained by execute-stage resolution. Optional BPU_STATS_EN adds counters.
module bpu #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned INDEX_W     = 4,
    parameter int unsigned TAG_W       = 10,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              next_taken_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    output logic [31:0]       stat_upd_cnt_o,
    output logic [31:0]       stat_miss_cnt_o
);

    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_MSB = INDEX_W + 1;
    localparam int unsigned TAG_LSB = INDEX_W + 2;
    localparam int unsigned TAG_MSB = INDEX_W + TAG_W + 1;

    logic              valid_q  [BTB_ENTRIES];
    logic              valid_d  [BTB_ENTRIES];
    logic [1:0]        ctr_q    [BTB_ENTRIES];
    logic [1:0]        ctr_d    [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_d    [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_q [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_d [BTB_ENTRIES];

    logic [INDEX_W-1:0] idx_c;
    logic [TAG_W-1:0]   tag_c;
    logic               hit_c;
    logic [INDEX_W-1:0] uidx_c;
    logic [TAG_W-1:0]   utag_c;
    logic               uhit_c;

    // Lookup: reads pre-update contents, no bypass from the update port.
    assign idx_c        = pc_i[IDX_MSB:IDX_LSB];
    assign tag_c        = pc_i[TAG_MSB:TAG_LSB];
    assign hit_c        = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign next_taken_o = hit_c && ctr_q[idx_c][1];
    assign next_pc_o    = next_taken_o ? target_q[idx_c] : pc_i + ADDR_W'(4);

    assign uidx_c = upd_pc_i[IDX_MSB:IDX_LSB];
    assign utag_c = upd_pc_i[TAG_MSB:TAG_LSB];
    assign uhit_c = valid_q[uidx_c] && (tag_q[uidx_c] == utag_c);

    // Training: counter update on hit, allocation on taken miss.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_valid_i) begin
            if (uhit_c) begin
                if (upd_taken_i) begin
                    if (ctr_q[uidx_c] != 2'b11) begin
                        ctr_d[uidx_c] = ctr_q[uidx_c] + 2'b01;
                    end
                    target_d[uidx_c] = upd_target_i;
                end else if (ctr_q[uidx_c] != 2'b00) begin
                    ctr_d[uidx_c] = ctr_q[uidx_c] - 2'b01;
                end
            end else if (upd_taken_i) begin
                valid_d[uidx_c]  = 1'b1;
                tag_d[uidx_c]    = utag_c;
                target_d[uidx_c] = upd_target_i;
                ctr_d[uidx_c]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            valid_q <= '{default: 1'b0};
            ctr_q   <= '{default: 2'b01};
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag/target need no reset: they are qualified by valid.
    always_ff @(posedge clk_i) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_upd_cnt_q;
    logic [31:0] stat_upd_cnt_d;
    logic [31:0] stat_miss_cnt_q;
    logic [31:0] stat_miss_cnt_d;
    logic        unused_c;

    always_comb begin
        stat_upd_cnt_d  = stat_upd_cnt_q;
        stat_miss_cnt_d = stat_miss_cnt_q;
        if (upd_valid_i) begin
            stat_upd_cnt_d = stat_upd_cnt_q + 32'd1;
            if (upd_mispredict_i) begin
                stat_miss_cnt_d = stat_miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            stat_upd_cnt_q  <= 32'd0;
            stat_miss_cnt_q <= 32'd0;
        end else begin
            stat_upd_cnt_q  <= stat_upd_cnt_d;
            stat_miss_cnt_q <= stat_miss_cnt_d;
        end
    end

    assign stat_upd_cnt_o  = stat_upd_cnt_q;
    assign stat_miss_cnt_o = stat_miss_cnt_q;
    assign unused_c        = ^upd_pc_i;
`else
    logic unused_c;

    assign stat_upd_cnt_o  = 32'd0;
    assign stat_miss_cnt_o = 32'd0;
    assign unused_c        = ^{upd_pc_i, upd_mispredict_i};
`endif

endmodule

// File: tb/tb_bpu.sv
// Randomized scoreboard bench for bpu against an array-based reference model.
module tb_bpu;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IW      = 4;
    localparam int unsigned TW      = 10;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic [31:0] pc_i;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;
    logic [31:0] stat_upd_cnt_o;
    logic [31:0] stat_miss_cnt_o;

    bpu dut (
        .clk_i            (clk_i),
        .n_rst_i          (n_rst_i),
        .pc_i             (pc_i),
        .next_pc_o        (next_pc_o),
        .next_taken_o     (next_taken_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_mispredict_i (upd_mispredict_i),
        .stat_upd_cnt_o   (stat_upd_cnt_o),
        .stat_miss_cnt_o  (stat_miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          v;
        int unsigned tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        taken;
        logic [31:0] upd_cnt;
        logic [31:0] miss_cnt;
    } exp_t;

    ent_t        model [ENTRIES];
    logic [31:0] m_upd;
    logic [31:0] m_miss;
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            model[i].v   = 1'b0;
            model[i].ctr = 1;
        end
        m_upd  = 32'd0;
        m_miss = 32'd0;
    endtask

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (int'(pc) >>> 0 == 0) ? 0 : ((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return (pc >> (2 + IW)) % (1 << TW);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // One cycle: drive inputs, record expected lookup, then advance the model.
    task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utgt, input bit um,
                        input bit rstn, input string nm);
        exp_t        e;
        int unsigned i;
        int unsigned t;
        bit          hit;
        @(posedge clk_i);
        #1;
        n_rst_i          = rstn;
        pc_i             = pc;
        upd_valid_i      = uv;
        upd_pc_i         = upc;
        upd_taken_i      = ut;
        upd_target_i     = utgt;
        upd_mispredict_i = um;
        if (!rstn) model_reset();
        i       = f_idx(pc);
        hit     = model[i].v && model[i].tag == f_tag(pc);
        e.name  = nm;
        e.taken = hit && model[i].ctr >= 2;
        e.npc   = e.taken ? model[i].tgt : pc + 32'd4;
`ifdef BPU_STATS_EN
        e.upd_cnt  = m_upd;
        e.miss_cnt = m_miss;
`else
        e.upd_cnt  = 32'd0;
        e.miss_cnt = 32'd0;
`endif
        sb.push_back(e);
        if (rstn && uv) begin
            m_upd  = m_upd + 32'd1;
            if (um) m_miss = m_miss + 32'd1;
            i = f_idx(upc);
            t = f_tag(upc);
            if (model[i].v && model[i].tag == t) begin
                if (ut) begin
                    model[i].ctr = (model[i].ctr == 3) ? 3 : model[i].ctr + 1;
                    model[i].tgt = utgt;
                end else begin
                    model[i].ctr = (model[i].ctr == 0) ? 0 : model[i].ctr - 1;
                end
            end else if (ut) begin
                model[i].v   = 1'b1;
                model[i].tag = t;
                model[i].tgt = utgt;
                model[i].ctr = 2;
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input string nm);
        step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, nm);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit um, input string nm);
        step(pc, 1'b1, upc, ut, utgt, um, 1'b1, nm);
    endtask

    // Monitor: the lookup is live every cycle; compare one expectation per cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".next_pc"}, next_pc_o, e.npc);
            check({e.name, ".taken"}, 32'(next_taken_o), 32'(e.taken));
            check({e.name, ".upd_cnt"}, stat_upd_cnt_o, e.upd_cnt);
            check({e.name, ".miss_cnt"}, stat_miss_cnt_o, e.miss_cnt);
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] upc;
        int          budget;
        n_rst_i = 1'b0; pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0;
        upd_taken_i = 1'b0; upd_target_i = '0; upd_mispredict_i = 1'b0;
        model_reset();

        // Reset state and +4 wrap.
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rst_100");
        step(32'hFFFFFFFC, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, "rst_wrap");
        look(32'hFFFFFFFC, "wrap");
        look(32'h100, "cold_100");

        // Allocate, then counter walk with saturation.
        train(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, "alloc");
        look(32'h100, "alloc_hit");
        train(32'h101, 32'h100, 1'b0, 32'h0, 1'b1, "nt1");
        train(32'h100, 32'h100, 1'b0, 32'h0, 1'b0, "nt2");
        train(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, "t1");
        train(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, "t2");
        train(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, "t3");
        train(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, "nt_sat");
        look(32'h100, "after_sat");

        // Alias eviction and not-taken miss.
        train(32'h140, 32'h140, 1'b1, 32'h300, 1'b0, "evict");
        look(32'h100, "evicted");
        look(32'h140, "new_owner");
        train(32'h180, 32'h180, 1'b0, 32'h0, 1'b0, "nt_miss");
        look(32'h140, "unchanged");
        look(32'h180, "nt_miss_look");

        // Same-cycle lookup/update: no bypass.
        train(32'h100, 32'h100, 1'b1, 32'h400, 1'b0, "same_cyc");
        look(32'h100, "same_next");

        // Mid-run reset clears the table and statistics at once.
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b1, 1'b0, "mid_rst");
        look(32'h100, "post_rst");

        // Random traffic over a small PC pool to force hits and aliasing.
        for (int k = 0; k < 600; k++) begin
            pc  = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3) | (($urandom & 1) << 20);
            upc = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 30) == 0) pc = 32'hFFFFFFFC;
            step(pc, ($urandom & 1) == 1, upc, $urandom_range(0, 2) != 0,
                 $urandom & 32'hFFFFFFFC, ($urandom & 1) == 1,
                 $urandom_range(0, 150) != 0, "rnd");
        end

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
